led_ctrl: RTL

LED_CTRL -- requirements
Module: led_ctrl

---
 rtl/led_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/led_ctrl.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM with a shared tick
// prescaler and a shared free-running 8-bit PWM phase.
module led_ctrl #(
    parameter int unsigned NCH        = 8,
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned TICK_HZ    = 1000,
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned DEF_PERIOD = 500
) (
    input  logic                                     sys_clk,
    input  logic                                     sys_rst,
    input  logic                                     cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                               cfg_mode,
    input  logic [PERIOD_W-1:0]                      cfg_period,
    input  logic [7:0]                               cfg_duty,
    input  logic                                     restart,
    output logic [NCH-1:0]                           led,
    output logic                                     tick
);

    localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
    localparam int unsigned PRESC_W = $clog2(DIV);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    logic [PRESC_W-1:0] presc;
    logic [7:0]         pwm_phase;

    // Shared timebase: prescaler, registered tick pulse and PWM phase.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            presc     <= '0;
            tick      <= 1'b0;
            pwm_phase <= '0;
        end else if (restart) begin
            presc     <= '0;
            tick      <= 1'b0;
            pwm_phase <= '0;
        end else begin
            presc     <= (presc == PRESC_W'(DIV - 1)) ? '0 : presc + PRESC_W'(1);
            tick      <= (presc == PRESC_W'(DIV - 1));
            pwm_phase <= pwm_phase + 8'd1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mode_e               mode_q;
        logic [PERIOD_W-1:0] period_q;
        logic [7:0]          duty_q;
        logic [PERIOD_W-1:0] cnt_q;
        logic                blink_q;
        logic                led_q;
        logic                wr_c;
        logic                led_c;

        // Out-of-range channel numbers match no channel and are dropped.
        always_comb begin
            wr_c  = cfg_we && (cfg_ch == CH_W'(i));
            led_c = 1'b0;
            case (mode_q)
                MODE_OFF:   led_c = 1'b0;
                MODE_ON:    led_c = 1'b1;
                MODE_BLINK: led_c = blink_q;
                MODE_PWM:   led_c = (pwm_phase < duty_q);
                default:    led_c = 1'b0;
            endcase
        end

        // A write takes precedence over restart and over a same-cycle wrap.
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                mode_q   <= MODE_OFF;
                period_q <= PERIOD_W'(DEF_PERIOD);
                duty_q   <= '0;
                cnt_q    <= '0;
                blink_q  <= 1'b0;
                led_q    <= 1'b0;
            end else begin
                led_q <= led_c;
                if (wr_c) begin
                    mode_q   <= mode_e'(cfg_mode);
                    period_q <= (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
                    duty_q   <= cfg_duty;
                    cnt_q    <= '0;
                    blink_q  <= 1'b0;
                end else if (restart) begin
                    cnt_q   <= '0;
                    blink_q <= 1'b0;
                end else if (mode_q != MODE_BLINK) begin
                    cnt_q <= '0;
                end else if (tick) begin
                    if (cnt_q == period_q - PERIOD_W'(1)) begin
                        cnt_q   <= '0;
                        blink_q <= ~blink_q;
                    end else begin
                        cnt_q <= cnt_q + PERIOD_W'(1);
                    end
                end
            end
        end

        assign led[i] = led_q;
    end

endmodule
